// File: rtl/mas_pkg.sv
// rtl/mas_pkg.sv - shared types and constants for the multiply/add/sub result collector
// Purpose: sample field widths, collector FSM states and the per-frame extreme/flag record.
// Ports: none (package).
package mas_pkg;

  localparam int DOUT_W    = 4;
  localparam int TCMP_W    = 2;
  localparam int NUM_CODES = 4;

  // Sentinels loaded into the running min/max so that the first sample always replaces them.
  localparam logic signed [DOUT_W-1:0] MIN_SENTINEL = 4'sb0111;
  localparam logic signed [DOUT_W-1:0] MAX_SENTINEL = 4'sb1000;

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } state_e;

  // Width-independent part of a frame summary. Sum, length and histogram depend on the
  // collector parameters and are kept next to this record in the top level.
  typedef struct packed {
    logic signed [DOUT_W-1:0] min;
    logic signed [DOUT_W-1:0] max;
    logic                     sat;
  } frame_ext_t;

endpackage

// File: rtl/mas_result_collector_if.sv
// rtl/mas_result_collector_if.sv - sample input stream and frame summary output stream
// Purpose: bundles both valid/ready channels of the collector.
// Ports (slave = collector side):
//   in_valid/in_ready/in_dout/in_tcmp/in_last    sample stream into the collector
//   out_valid/out_ready/out_sum/out_min/out_max/
//   out_len/out_hist/out_sat                      frame summary stream out of the collector
interface mas_result_collector_if
  import mas_pkg::*;
#(
  parameter int SUM_W = 8,
  parameter int CNT_W = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [DOUT_W-1:0]      in_dout;
  logic [TCMP_W-1:0]      in_tcmp;
  logic                   in_last;

  logic                   out_valid;
  logic                   out_ready;
  logic [SUM_W-1:0]       out_sum;
  logic [DOUT_W-1:0]      out_min;
  logic [DOUT_W-1:0]      out_max;
  logic [CNT_W-1:0]       out_len;
  logic [NUM_CODES*CNT_W-1:0] out_hist;
  logic                   out_sat;

  modport master (
    output in_valid, in_dout, in_tcmp, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_min, out_max, out_len, out_hist, out_sat
  );

  modport slave (
    input  in_valid, in_dout, in_tcmp, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_min, out_max, out_len, out_hist, out_sat
  );

endinterface

// File: rtl/mas_sat_add.sv
// rtl/mas_sat_add.sv - signed accumulate of one sample with clamping
// Purpose: sign-extends acc and sample to SUM_W+1 bits, adds, clamps to the SUM_W range.
// Ports:
//   acc     in   SUM_W   current signed sum
//   sample  in   DOUT_W  signed sample
//   result  out  SUM_W   clamped sum
//   sat     out  1       clamping happened on this addition
module mas_sat_add
  import mas_pkg::*;
#(
  parameter int SUM_W = 8
) (
  input  logic [SUM_W-1:0]  acc,
  input  logic [DOUT_W-1:0] sample,
  output logic [SUM_W-1:0]  result,
  output logic              sat
);

  logic [SUM_W:0] wide;

  always_comb begin
    wide = {acc[SUM_W-1], acc} + {{(SUM_W + 1 - DOUT_W){sample[DOUT_W-1]}}, sample};
    // One extra bit holds any sum of an in-range acc and a 4-bit sample, so the top two
    // bits disagree exactly when the true result left the SUM_W range.
    sat = wide[SUM_W] ^ wide[SUM_W-1];
    if (!sat) begin
      result = wide[SUM_W-1:0];
    end else if (wide[SUM_W]) begin
      result = {1'b1, {(SUM_W - 1){1'b0}}};
    end else begin
      result = {1'b0, {(SUM_W - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/mas_result_collector.sv
// rtl/mas_result_collector.sv - frames Dout/Tcmp samples and publishes per-frame statistics
// Purpose: accumulates saturated sum, min, max, length and Tcmp histogram over up to
//   FRAME_LEN samples (or until in_last), then holds the summary until accepted.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of mas_result_collector_if (sample in, summary out)
module mas_result_collector
  import mas_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 8,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mas_result_collector_if.slave bus
);

  state_e             state_q;
  state_e             state_nxt;
  logic               active_q;

  logic [SUM_W-1:0]   sum_q;
  logic [SUM_W-1:0]   sum_add;
  logic               add_sat;
  frame_ext_t         ext_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   len_inc;
  logic [CNT_W-1:0]   hist_q [NUM_CODES];
  logic [NUM_CODES*CNT_W-1:0] hist_flat;

  logic               accept;
  logic               release_frame;
  logic               ready;
  logic               valid;
  logic signed [DOUT_W-1:0] sample;

  assign sample  = $signed(bus.in_dout);
  assign len_inc = len_q + CNT_W'(1);

  mas_sat_add #(
    .SUM_W (SUM_W)
  ) u_sat_add (
    .acc    (sum_q),
    .sample (bus.in_dout),
    .result (sum_add),
    .sat    (add_sat)
  );

  // active_q keeps in_ready low during reset and for the release edge itself, so the
  // first sample can only be taken the cycle after rst_n goes high.
  always_comb begin
    state_nxt     = state_q;
    ready         = 1'b0;
    valid         = 1'b0;
    accept        = 1'b0;
    release_frame = 1'b0;
    case (state_q)
      ST_ACC: begin
        ready  = active_q;
        accept = active_q & bus.in_valid;
        if (accept && ((len_inc == CNT_W'(FRAME_LEN)) || bus.in_last)) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        valid = 1'b1;
        if (bus.out_ready) begin
          release_frame = 1'b1;
          state_nxt     = ST_ACC;
        end
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      active_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      active_q <= 1'b1;
    end
  end

  // Accumulators double as the summary registers: they are frozen in HOLD, so the
  // published values stay stable until the consumer takes them.
  always_ff @(posedge clk) begin
    if (!rst_n || release_frame) begin
      sum_q     <= '0;
      ext_q.min <= MIN_SENTINEL;
      ext_q.max <= MAX_SENTINEL;
      ext_q.sat <= 1'b0;
      len_q     <= '0;
      for (int k = 0; k < NUM_CODES; k++) begin
        hist_q[k] <= '0;
      end
    end else if (accept) begin
      sum_q     <= sum_add;
      ext_q.sat <= ext_q.sat | add_sat;
      if (sample < $signed(ext_q.min)) begin
        ext_q.min <= sample;
      end
      if (sample > $signed(ext_q.max)) begin
        ext_q.max <= sample;
      end
      len_q <= len_inc;
      hist_q[bus.in_tcmp] <= hist_q[bus.in_tcmp] + CNT_W'(1);
    end
  end

  always_comb begin
    hist_flat = '0;
    for (int k = 0; k < NUM_CODES; k++) begin
      hist_flat[k*CNT_W +: CNT_W] = hist_q[k];
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_sum   = sum_q;
  assign bus.out_min   = ext_q.min;
  assign bus.out_max   = ext_q.max;
  assign bus.out_len   = len_q;
  assign bus.out_hist  = hist_flat;
  assign bus.out_sat   = ext_q.sat;

endmodule

// File: tb/tb_mas_result_collector.sv
// tb/tb_mas_result_collector.sv - directed self-checking bench for mas_result_collector
module tb_mas_result_collector;
  import mas_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mas_result_collector_if #(.SUM_W(8), .CNT_W(4)) a ();
  mas_result_collector_if #(.SUM_W(5), .CNT_W(4)) b ();

  mas_result_collector #(.FRAME_LEN(8), .SUM_W(8), .CNT_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  mas_result_collector #(.FRAME_LEN(8), .SUM_W(5), .CNT_W(4)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [3:0] d, input logic [1:0] t, input logic l);
    int n = 0;
    if (sel) begin
      b.in_valid = 1'b1; b.in_dout = d; b.in_tcmp = t; b.in_last = l;
    end else begin
      a.in_valid = 1'b1; a.in_dout = d; a.in_tcmp = t; a.in_last = l;
    end
    @(negedge clk);
    while (!(sel ? b.in_ready : a.in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("push_ready_timeout", 32'(sel ? b.in_ready : a.in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (sel) begin
      b.in_valid = 1'b0; b.in_last = 1'b0;
    end else begin
      a.in_valid = 1'b0; a.in_last = 1'b0;
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] sum, input logic [3:0] mn,
                       input logic [3:0] mx, input logic [3:0] len, input logic [15:0] hist,
                       input logic sat);
    chk({tag, "_valid"}, 32'(a.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(a.out_sum),   32'(sum));
    chk({tag, "_min"},   32'(a.out_min),   32'(mn));
    chk({tag, "_max"},   32'(a.out_max),   32'(mx));
    chk({tag, "_len"},   32'(a.out_len),   32'(len));
    chk({tag, "_hist"},  32'(a.out_hist),  32'(hist));
    chk({tag, "_sat"},   32'(a.out_sat),   32'(sat));
    chk({tag, "_ready"}, 32'(a.in_ready),  32'd0);
  endtask

  task automatic chk_b(input string tag, input logic [4:0] sum, input logic [3:0] mn,
                       input logic [3:0] mx, input logic [3:0] len, input logic [15:0] hist,
                       input logic sat);
    chk({tag, "_valid"}, 32'(b.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(b.out_sum),   32'(sum));
    chk({tag, "_min"},   32'(b.out_min),   32'(mn));
    chk({tag, "_max"},   32'(b.out_max),   32'(mx));
    chk({tag, "_len"},   32'(b.out_len),   32'(len));
    chk({tag, "_hist"},  32'(b.out_hist),  32'(hist));
    chk({tag, "_sat"},   32'(b.out_sat),   32'(sat));
  endtask

  task automatic release_a();
    a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    a.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] full_d [8];
    logic [1:0] full_t [8];
    full_d = '{4'hD, 4'h2, 4'h7, 4'h8, 4'h0, 4'h1, 4'h4, 4'hF};
    full_t = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    a.in_valid = 1'b0; a.in_dout = '0; a.in_tcmp = '0; a.in_last = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_dout = '0; b.in_tcmp = '0; b.in_last = 1'b0; b.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("rst_in_ready",  32'(a.in_ready),  32'd0);
    chk("rst_len",       32'(a.out_len),   32'd0);
    chk("rst_sum",       32'(a.out_sum),   32'd0);
    chk("rst_min",       32'(a.out_min),   32'h7);
    chk("rst_max",       32'(a.out_max),   32'h8);
    chk("rst_hist",      32'(a.out_hist),  32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(a.in_ready), 32'd1);

    // Full frame, out_ready held high (ignored while accumulating)
    a.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(1'b0, full_d[i], full_t[i], 1'b0);
      if (i == 6) chk("full_not_yet_valid", 32'(a.out_valid), 32'd0);
    end
    chk_a("full", 8'h02, 4'h8, 4'h7, 4'd8, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    chk("full_handoff_valid", 32'(a.out_valid), 32'd0);
    chk("full_handoff_ready", 32'(a.in_ready),  32'd1);
    chk("full_cleared_len",   32'(a.out_len),   32'd0);

    // Early last on first sample
    push(1'b0, 4'hB, 2'd2, 1'b1);
    chk_a("single", 8'hFB, 4'hB, 4'hB, 4'd1, 16'h0100, 1'b0);
    @(posedge clk);
    #1;
    a.out_ready = 1'b0;

    // Saturation on the SUM_W=5 instance
    b.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(1'b1, 4'h7, 2'd0, 1'b0);
    chk_b("satpos", 5'h0F, 4'h7, 4'h7, 4'd8, 16'h0008, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push(1'b1, 4'h8, 2'd0, 1'b0);
    chk_b("satneg", 5'h10, 4'h8, 4'h8, 4'd8, 16'h0008, 1'b1);
    @(posedge clk);
    #1;
    b.out_ready = 1'b0;

    // Backpressure with a sample waiting upstream
    for (int i = 0; i < 8; i++) push(1'b0, 4'h1, 2'd3, 1'b0);
    chk_a("bp", 8'h08, 4'h1, 4'h1, 4'd8, 16'h8000, 1'b0);
    a.in_valid = 1'b1; a.in_dout = 4'h2; a.in_tcmp = 2'd0; a.in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(a.out_valid), 32'd1);
      chk("bp_hold_ready", 32'(a.in_ready),  32'd0);
      chk("bp_hold_sum",   32'(a.out_sum),   32'h08);
      chk("bp_hold_len",   32'(a.out_len),   32'd8);
    end
    release_a();
    push(1'b0, 4'h2, 2'd0, 1'b0);
    push(1'b0, 4'h3, 2'd1, 1'b1);
    chk_a("bp_next", 8'h05, 4'h2, 4'h3, 4'd2, 16'h0011, 1'b0);
    release_a();

    // Mid-frame reset discards the partial frame
    for (int i = 0; i < 4; i++) push(1'b0, 4'h7, 2'd1, 1'b0);
    chk("mid_len_before", 32'(a.out_len), 32'd4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(a.out_valid), 32'd0);
    chk("mid_rst_len",   32'(a.out_len),   32'd0);
    chk("mid_rst_ready", 32'(a.in_ready),  32'd0);
    for (int i = 0; i < 8; i++) push(1'b0, 4'hF, 2'd2, 1'b0);
    chk_a("mid_after", 8'hF8, 4'hF, 4'hF, 4'd8, 16'h0800, 1'b0);
    release_a();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
